// File: rtl/imem_loader.sv
// Byte-addressed Y86 instruction memory: a registered 10-byte fetch window, plus a serial
// loader that takes a 4-byte header (address, length) followed by the program bytes.
module imem_loader #(
    parameter int IMEM_BYTES = 1024,
    parameter int WIN_BYTES  = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   rd_en,
    input  logic [63:0]            rd_pc,
    output logic [8*WIN_BYTES-1:0] rd_data,
    output logic                   rd_valid,
    output logic                   rd_error,
    input  logic                   ld_start,
    input  logic                   ld_valid,
    input  logic [7:0]             ld_byte,
    output logic                   ld_ready,
    output logic                   ld_busy,
    output logic                   ld_done,
    output logic                   ld_err
);

    localparam int AW = $clog2(IMEM_BYTES);
    localparam logic [63:0] LIMIT64 = 64'(IMEM_BYTES);
    localparam logic [64:0] LIMIT65 = 65'(IMEM_BYTES);
    localparam logic [16:0] LIMIT17 = 17'(IMEM_BYTES);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        A0   = 3'd1,
        A1   = 3'd2,
        L0   = 3'd3,
        L1   = 3'd4,
        DATA = 3'd5,
        DONE = 3'd6
    } state_t;

    logic [7:0] mem [IMEM_BYTES];

    state_t state_r, state_next_s;
    logic [15:0] addr_r, addr_next_s;
    logic [15:0] len_r, len_next_s;
    logic [15:0] count_r, count_next_s;
    logic discard_r, discard_next_s;
    logic ld_err_r, err_next_s;
    logic ld_ready_r, ld_busy_r, ld_done_r;
    logic busy_next_s;

    logic xfer_s;
    logic [15:0] len_full_s;
    logic [16:0] end_sum_s;
    logic [16:0] wr_addr_s;
    logic mem_we_s;

    logic [8*WIN_BYTES-1:0] win_s;
    logic [64:0] byte_addr_s;
    logic rd_error_s;
    logic [8*WIN_BYTES-1:0] rd_data_r;
    logic rd_valid_r, rd_error_r;

    assign xfer_s     = ld_valid && ld_ready_r;
    assign len_full_s = {ld_byte, len_r[7:0]};
    assign end_sum_s  = {1'b0, addr_r} + {1'b0, len_full_s};
    assign wr_addr_s  = {1'b0, addr_r} + {1'b0, count_r};

    // Loader next-state logic: header capture, range check and data counting
    always_comb begin
        state_next_s   = state_r;
        addr_next_s    = addr_r;
        len_next_s     = len_r;
        count_next_s   = count_r;
        discard_next_s = discard_r;
        err_next_s     = ld_err_r;
        mem_we_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (ld_start) begin
                    state_next_s   = A0;
                    err_next_s     = 1'b0;
                    discard_next_s = 1'b0;
                    count_next_s   = 16'd0;
                end else begin
                    state_next_s = IDLE;
                end
            end
            A0: begin
                if (xfer_s) begin
                    addr_next_s[7:0] = ld_byte;
                    state_next_s     = A1;
                end else begin
                    state_next_s = A0;
                end
            end
            A1: begin
                if (xfer_s) begin
                    addr_next_s[15:8] = ld_byte;
                    state_next_s      = L0;
                end else begin
                    state_next_s = A1;
                end
            end
            L0: begin
                if (xfer_s) begin
                    len_next_s[7:0] = ld_byte;
                    state_next_s    = L1;
                end else begin
                    state_next_s = L0;
                end
            end
            L1: begin
                if (xfer_s) begin
                    len_next_s[15:8] = ld_byte;
                    // An image running past the end is swallowed without touching memory
                    if (end_sum_s > LIMIT17) begin
                        err_next_s     = 1'b1;
                        discard_next_s = 1'b1;
                    end else begin
                        discard_next_s = 1'b0;
                    end
                    if (len_full_s == 16'd0) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = L1;
                end
            end
            DATA: begin
                if (xfer_s) begin
                    mem_we_s     = !discard_r;
                    count_next_s = count_r + 16'd1;
                    if (count_r + 16'd1 == len_r) begin
                        state_next_s = DONE;
                    end else begin
                        state_next_s = DATA;
                    end
                end else begin
                    state_next_s = DATA;
                end
            end
            DONE: begin
                state_next_s = IDLE;
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    assign busy_next_s = (state_next_s != IDLE) && (state_next_s != DONE);

    // Loader state and registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            addr_r     <= 16'd0;
            len_r      <= 16'd0;
            count_r    <= 16'd0;
            discard_r  <= 1'b0;
            ld_err_r   <= 1'b0;
            ld_ready_r <= 1'b0;
            ld_busy_r  <= 1'b0;
            ld_done_r  <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            addr_r     <= addr_next_s;
            len_r      <= len_next_s;
            count_r    <= count_next_s;
            discard_r  <= discard_next_s;
            ld_err_r   <= err_next_s;
            ld_ready_r <= busy_next_s;
            ld_busy_r  <= busy_next_s;
            ld_done_r  <= (state_next_s == DONE) && !err_next_s;
        end
    end

    // Memory write port; the array itself is never reset
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[wr_addr_s[AW-1:0]] <= ld_byte;
        end
    end

    // Fetch window assembly; bytes beyond the array read as halt (8'h00)
    always_comb begin
        win_s       = '0;
        byte_addr_s = 65'd0;
        for (int k = 0; k < WIN_BYTES; k++) begin
            byte_addr_s = {1'b0, rd_pc} + 65'(k);
            if (byte_addr_s < LIMIT65) begin
                win_s[8*k +: 8] = mem[byte_addr_s[AW-1:0]];
            end else begin
                win_s[8*k +: 8] = 8'h00;
            end
        end
    end

    assign rd_error_s = (rd_pc >= LIMIT64) || ld_busy_r;

    // Fetch response register; data holds between requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            rd_error_r <= 1'b0;
        end else begin
            rd_valid_r <= rd_en;
            if (rd_en) begin
                rd_data_r  <= win_s;
                rd_error_r <= rd_error_s;
            end else begin
                rd_data_r  <= rd_data_r;
                rd_error_r <= rd_error_r;
            end
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign rd_error = rd_error_r;
    assign ld_ready = ld_ready_r;
    assign ld_busy  = ld_busy_r;
    assign ld_done  = ld_done_r;
    assign ld_err   = ld_err_r;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: reference memory model, read scoreboard and loader handshake driver.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic [63:0] rd_pc = 64'd0;
    logic [79:0] rd_data;
    logic        rd_valid, rd_error;
    logic        ld_start = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_byte = 8'd0;
    logic        ld_ready, ld_busy, ld_done, ld_err;

    imem_loader #(.IMEM_BYTES(1024), .WIN_BYTES(10)) dut (
        .clk(clk), .rst_n(rst_n),
        .rd_en(rd_en), .rd_pc(rd_pc), .rd_data(rd_data), .rd_valid(rd_valid), .rd_error(rd_error),
        .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte),
        .ld_ready(ld_ready), .ld_busy(ld_busy), .ld_done(ld_done), .ld_err(ld_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [79:0] d;
        logic        e;
    } exp_t;
    typedef logic [7:0] bq_t [$];

    int checks = 0;
    int errors = 0;
    int xfer_cnt = 0;
    int done_cnt = 0;
    logic [7:0] m_mem [0:1023];
    exp_t sb [$];
    exp_t mon_e;
    logic en_q;

    task automatic check_val(input string tag, input logic [79:0] got, input logic [79:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [79:0] exp_win(input logic [63:0] pc);
        logic [79:0] w;
        logic [64:0] a;
        w = '0;
        for (int k = 0; k < 10; k++) begin
            a = {1'b0, pc} + 65'(k);
            if (a < 65'd1024) w[8*k +: 8] = m_mem[a[9:0]];
        end
        return w;
    endfunction

    // Monitor: transfer/done counting, rd_valid latency and scoreboard pops
    always @(posedge clk) begin
        en_q = rd_en;
        if (ld_valid && ld_ready) xfer_cnt++;
        #1;
        if (rst_n) begin
            check_val("rd_valid_latency", rd_valid, en_q);
            if (rd_valid) begin
                if (sb.size() == 0) begin
                    check_val("sb_underflow", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check_val("rd_data", rd_data, mon_e.d);
                    check_val("rd_error", rd_error, mon_e.e);
                end
            end
        end
        if (ld_done) done_cnt++;
    end

    task automatic do_read(input logic [63:0] pc);
        exp_t e;
        e.d = exp_win(pc);
        e.e = (pc >= 64'd1024) || ld_busy;
        sb.push_back(e);
        rd_en = 1'b1;
        rd_pc = pc;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic do_load(input logic [15:0] addr, input bq_t data, input bit gaps,
                           input int extra_start, input bit exp_err);
        bq_t s;
        logic [15:0] len16;
        int idx, budget, x0, d0;
        bit v, rdy, started;
        len16 = 16'(data.size());
        s.push_back(addr[7:0]);
        s.push_back(addr[15:8]);
        s.push_back(len16[7:0]);
        s.push_back(len16[15:8]);
        foreach (data[i]) s.push_back(data[i]);
        x0 = xfer_cnt;
        d0 = done_cnt;
        started = 1'b0;
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        check_val("ld_busy_on_start", ld_busy, 1);
        check_val("ld_err_cleared", ld_err, 0);
        idx = 0;
        budget = 0;
        while (idx < s.size() && budget < 4000) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            ld_valid = v;
            ld_byte = s[idx];
            if (idx == extra_start && !started) begin
                ld_start = 1'b1;
                started = 1'b1;
            end
            rdy = ld_ready;
            @(negedge clk);
            ld_start = 1'b0;
            budget++;
            if (v && rdy) begin
                idx++;
                if (idx == 4) check_val("ld_err_after_L1", ld_err, exp_err);
            end
        end
        ld_valid = 1'b0;
        if (budget >= 4000) check_val("load_timeout", 0, 1);
        check_val("ld_done_pulse", ld_done, !exp_err);
        check_val("ld_busy_at_done", ld_busy, 0);
        check_val("ld_err_final", ld_err, exp_err);
        if (!exp_err) begin
            foreach (data[i]) m_mem[int'(addr) + i] = data[i];
        end
        @(negedge clk);
        check_val("ld_done_width", ld_done, 0);
        check_val("xfer_count", xfer_cnt - x0, s.size());
        check_val("done_count", done_cnt - d0, exp_err ? 0 : 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bq_t d;
        exp_t e;
        int d0;
        logic [7:0] hdr [4];

        @(posedge clk);
        #3;
        check_val("rst_rd_valid", rd_valid, 0);
        check_val("rst_rd_data", rd_data, 80'd0);
        check_val("rst_ld_ready", ld_ready, 0);
        check_val("rst_ld_busy", ld_busy, 0);
        check_val("rst_ld_done", ld_done, 0);
        check_val("rst_ld_err", ld_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Fill the whole array so every later window is fully defined
        d.delete();
        for (int i = 0; i < 1024; i++) d.push_back(8'(i * 7 + 3));
        do_load(16'h0000, d, 1'b0, -1, 1'b0);

        d.delete();
        d.push_back(8'h30); d.push_back(8'hF3); d.push_back(8'h0A); d.push_back(8'h00);
        do_load(16'h0000, d, 1'b0, -1, 1'b0);
        do_read(64'd0);
        check_val("t1_word", rd_data[31:0], 32'h000AF330);

        d.delete();
        for (int i = 0; i < 10; i++) d.push_back(8'($urandom_range(0, 255)));
        do_load(16'h0010, d, 1'b0, -1, 1'b0);
        do_read(64'd16);

        do_read(64'd1024);
        do_read(64'hFFFF_FFFF_FFFF_FFFF);
        do_read(64'd1020);
        check_val("t3_tail_zero", rd_data[79:32], 48'd0);
        do_read(64'd1023);

        d.delete();
        for (int i = 0; i < 4; i++) d.push_back(8'h55);
        do_load(16'h03FE, d, 1'b0, -1, 1'b1);
        do_read(64'd1020);

        d.delete();
        for (int i = 0; i < 6; i++) d.push_back(8'($urandom_range(0, 255)));
        do_load(16'h0100, d, 1'b1, 6, 1'b0);
        do_read(64'h100);

        // Reset in the middle of a 5-byte load at 0x200
        d0 = done_cnt;
        hdr[0] = 8'h00; hdr[1] = 8'h02; hdr[2] = 8'h05; hdr[3] = 8'h00;
        ld_start = 1'b1;
        @(negedge clk);
        ld_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_val("rst_seq_ready", ld_ready, 1);
            ld_valid = 1'b1;
            ld_byte = hdr[i];
            @(negedge clk);
        end
        ld_byte = 8'hA1;
        e.d = exp_win(64'h200);
        e.e = 1'b1;
        sb.push_back(e);
        rd_en = 1'b1;
        rd_pc = 64'h200;
        @(negedge clk);
        rd_en = 1'b0;
        m_mem[10'h200] = 8'hA1;
        ld_byte = 8'hB2;
        @(negedge clk);
        m_mem[10'h201] = 8'hB2;
        ld_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("midrst_busy", ld_busy, 0);
        check_val("midrst_ready", ld_ready, 0);
        check_val("midrst_done", ld_done, 0);
        check_val("midrst_rd_data", rd_data, 80'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check_val("midrst_no_done", done_cnt - d0, 0);
        do_read(64'h200);

        repeat (3) @(negedge clk);
        check_val("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
